// File: rtl/nibble_bus_writer.sv
// nibble_bus_writer
//
// Upstream command stage for the TBB1143 sound core. Register writes {addr, data}
// are queued in a small FIFO. Each write is then sent over the core's 4-bit write
// bus as three bus writes: the address nibble (A0=1), then the data low nibble,
// then the data high nibble (A0=0). Every bus write uses programmable
// setup/strobe/hold timing.
//
// Ports
//   CLK         system clock, rising edge
//   RST         synchronous, active-high reset
//   cmd_valid   host offers {cmd_addr, cmd_data} this cycle
//   cmd_ready   FIFO can accept; a push happens when cmd_valid & cmd_ready
//   cmd_addr    core register address
//   cmd_data    register value
//   D           bus data nibble to core D0..D3
//   A0          1 = address nibble, 0 = data nibble
//   WR          write strobe to core, active high
//   busy        FIFO non-empty or a bus write sequence still visible on the bus
//   fifo_level  number of entries currently stored in the FIFO
//
// All outputs are registered. D/A0/WR are decoded from the FSM state of the
// previous cycle. As a result the bus lags the FSM by one cycle, with a uniform
// offset across all phases.

module nibble_bus_writer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned HOLD_CYC   = 1
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [3:0]                    cmd_addr,
    input  logic [7:0]                    cmd_data,
    output logic [3:0]                    D,
    output logic                          A0,
    output logic                          WR,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
    localparam int unsigned LevelW = PtrW + 1;
    localparam int unsigned CntW   = 8;

    localparam logic [LevelW-1:0] LevelFull  = LevelW'(FIFO_DEPTH);
    localparam logic [CntW-1:0]   SetupLast  = CntW'(SETUP_CYC - 1);
    localparam logic [CntW-1:0]   StrobeLast = CntW'(STROBE_CYC - 1);
    localparam logic [CntW-1:0]   HoldLast   = CntW'(HOLD_CYC - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StStrobe,
        StHold
    } state_e;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [11:0]       mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LevelW-1:0] level_q, level_d;
    logic              ready_q;
    logic              push;
    logic              pop;
    logic              fifo_nonempty;
    logic [11:0]       fifo_head;

    // ready_q only reflects the registered level, so it never depends on a pop
    // happening in the same cycle.
    assign push          = cmd_valid & ready_q;
    assign fifo_nonempty = (level_q != '0);
    assign fifo_head     = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({push, pop})
            2'b10:   level_d = level_q + LevelW'(1);
            2'b01:   level_d = level_q - LevelW'(1);
            default: level_d = level_q;
        endcase
    end

    // Storage is datapath only; validity is tracked by the pointers and level.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_addr, cmd_data};
        end
    end

    // ------------------------------------------------------------------
    // Bus sequencer
    // ------------------------------------------------------------------
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      nibble_q, nibble_d;
    logic [11:0]     work_q, work_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        nibble_d = nibble_q;
        work_d   = work_q;
        pop      = 1'b0;

        case (state_q)
            StIdle: begin
                if (fifo_nonempty) begin
                    pop      = 1'b1;
                    work_d   = fifo_head;
                    nibble_d = 2'd0;
                    cnt_d    = '0;
                    state_d  = StSetup;
                end
            end

            StSetup: begin
                if (cnt_q == SetupLast) begin
                    cnt_d   = '0;
                    state_d = StStrobe;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            StStrobe: begin
                if (cnt_q == StrobeLast) begin
                    cnt_d   = '0;
                    state_d = StHold;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            StHold: begin
                if (cnt_q == HoldLast) begin
                    cnt_d = '0;
                    if (nibble_q != 2'd2) begin
                        nibble_d = nibble_q + 2'd1;
                        state_d  = StSetup;
                    end else if (fifo_nonempty) begin
                        // Chain straight into the next command without an idle cycle.
                        pop      = 1'b1;
                        work_d   = fifo_head;
                        nibble_d = 2'd0;
                        state_d  = StSetup;
                    end else begin
                        nibble_d = 2'd0;
                        state_d  = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode (registered one cycle behind the FSM)
    // ------------------------------------------------------------------
    logic [3:0] d_sel;
    logic       busy_d;
    logic       wr_q;
    logic       a0_q;
    logic [3:0] d_q;
    logic       busy_q;

    always_comb begin
        case (nibble_q)
            2'd0:    d_sel = work_q[11:8];
            2'd1:    d_sel = work_q[3:0];
            default: d_sel = work_q[7:4];
        endcase
    end

    // state_q is included so busy covers the last hold phase still on the bus.
    assign busy_d = (state_d != StIdle) || (level_d != '0) || (state_q != StIdle);

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ready_q  <= 1'b1;
            state_q  <= StIdle;
            cnt_q    <= '0;
            nibble_q <= 2'd0;
            work_q   <= '0;
            wr_q     <= 1'b0;
            a0_q     <= 1'b0;
            d_q      <= 4'h0;
            busy_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ready_q  <= (level_d != LevelFull);
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            nibble_q <= nibble_d;
            work_q   <= work_d;
            wr_q     <= (state_q == StStrobe);
            a0_q     <= (state_q != StIdle) && (nibble_q == 2'd0);
            d_q      <= (state_q == StIdle) ? 4'h0 : d_sel;
            busy_q   <= busy_d;
        end
    end

    assign cmd_ready  = ready_q;
    assign fifo_level = level_q;
    assign D          = d_q;
    assign A0         = a0_q;
    assign WR         = wr_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_nibble_bus_writer.sv
// Directed testbench for nibble_bus_writer. Instance dut uses the default timing
// (1/2/1). Instance dut2 uses setup/strobe/hold = 2/1/3.

module tb_nibble_bus_writer;

    logic       clk = 1'b0;
    logic       RST = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_addr = 4'h0;
    logic [7:0] cmd_data = 8'h00;
    logic [3:0] D;
    logic       A0;
    logic       WR;
    logic       busy;
    logic [2:0] fifo_level;

    logic       cmd_valid2 = 1'b0;
    logic       cmd_ready2;
    logic [3:0] cmd_addr2 = 4'h0;
    logic [7:0] cmd_data2 = 8'h00;
    logic [3:0] D2;
    logic       A02;
    logic       WR2;
    logic       busy2;
    logic [2:0] fifo_level2;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nibble_bus_writer dut (
        .CLK        (clk),
        .RST        (RST),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_data   (cmd_data),
        .D          (D),
        .A0         (A0),
        .WR         (WR),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    nibble_bus_writer #(
        .FIFO_DEPTH (4),
        .SETUP_CYC  (2),
        .STROBE_CYC (1),
        .HOLD_CYC   (3)
    ) dut2 (
        .CLK        (clk),
        .RST        (RST),
        .cmd_valid  (cmd_valid2),
        .cmd_ready  (cmd_ready2),
        .cmd_addr   (cmd_addr2),
        .cmd_data   (cmd_data2),
        .D          (D2),
        .A0         (A02),
        .WR         (WR2),
        .busy       (busy2),
        .fifo_level (fifo_level2)
    );

    task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        n_tests++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got_v, exp_v, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Bus monitors: record {A0, D} at every WR rising edge
    // ------------------------------------------------------------------
    logic [4:0] got_q[$];
    logic [4:0] exp_q[$];
    int         rise_t[$];

    logic       wr_p = 1'b0;
    logic       a0_p = 1'b0;
    logic [3:0] d_p  = 4'h0;
    bit         in_strobe = 1'b0;
    int         sw = 0;
    logic [4:0] cap = 5'h0;

    always @(negedge clk) begin
        if (RST) begin
            in_strobe = 1'b0;
            sw = 0;
        end else begin
            if (WR && !wr_p) begin
                got_q.push_back({A0, D});
                rise_t.push_back(cyc);
                check("setup_stable", {a0_p, d_p}, {A0, D});
                cap = {A0, D};
                in_strobe = 1'b1;
                sw = 0;
            end
            if (in_strobe) begin
                if (WR) begin
                    sw++;
                    check("strobe_stable", {A0, D}, cap);
                end else begin
                    check("strobe_width", sw, 2);
                    check("hold_stable", {A0, D}, cap);
                    in_strobe = 1'b0;
                end
            end
        end
        wr_p = WR;
        a0_p = A0;
        d_p  = D;
    end

    logic [4:0] got2_q[$];
    int         t2_q[$];
    int         w2_q[$];
    logic       wr2_p = 1'b0;
    int         w2 = 0;

    always @(negedge clk) begin
        if (!RST) begin
            if (WR2 && !wr2_p) begin
                got2_q.push_back({A02, D2});
                t2_q.push_back(cyc);
                w2 = 0;
            end
            if (WR2) begin
                w2++;
            end else if (wr2_p) begin
                w2_q.push_back(w2);
            end
        end
        wr2_p = WR2;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 time unit after a rising edge)
    // ------------------------------------------------------------------
    task automatic do_reset();
        RST = 1'b1;
        repeat (2) @(posedge clk);
        #1 RST = 1'b0;
    endtask

    task automatic push(input logic [3:0] a, input logic [7:0] d);
        bit r;
        bit ok;
        ok = 1'b0;
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_data  = d;
        for (int i = 0; i < 200; i++) begin
            r = cmd_ready;
            @(posedge clk);
            #1;
            if (r) begin
                ok = 1'b1;
                break;
            end
        end
        cmd_valid = 1'b0;
        if (!ok) check("push_timeout", 0, 1);
    endtask

    task automatic expect_cmd(input logic [3:0] a, input logic [7:0] d);
        exp_q.push_back({1'b1, a});
        exp_q.push_back({1'b0, d[3:0]});
        exp_q.push_back({1'b0, d[7:4]});
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy) check("idle_timeout", busy, 0);
    endtask

    task automatic compare_q(input string tag);
        int nbad;
        nbad = 0;
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            if (got_q[i] !== exp_q[i]) nbad++;
        end
        check({tag, "_order"}, nbad, 0);
        got_q.delete();
        exp_q.delete();
        rise_t.delete();
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        int n;
        int bad;
        logic [3:0] ra;
        logic [7:0] rd;

        // Reset state
        do_reset();
        check("rst_D", D, 4'h0);
        check("rst_A0", A0, 1'b0);
        check("rst_WR", WR, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_level", fifo_level, 3'd0);
        check("rst_ready", cmd_ready, 1'b1);

        // 1) Single command {5, A3} with exact latency
        expect_cmd(4'h5, 8'hA3);
        push(4'h5, 8'hA3);                       // edge N
        check("t1_level_push", fifo_level, 3'd1);
        check("t1_busy_push", busy, 1'b1);
        @(posedge clk); #1;                      // edge N+1: pop
        check("t1_level_pop", fifo_level, 3'd0);
        check("t1_D_before", D, 4'h0);
        @(posedge clk); #1;                      // edge N+2: first setup on bus
        check("t1_A0_setup", A0, 1'b1);
        check("t1_D_setup", D, 4'h5);
        check("t1_WR_setup", WR, 1'b0);
        @(posedge clk); #1;                      // edge N+3: strobe
        check("t1_WR_strobe", WR, 1'b1);
        n = 1;
        while (busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("t1_busy_fall", n, 12);
        check("t1_D_idle", D, 4'h0);
        check("t1_A0_idle", A0, 1'b0);
        compare_q("t1");

        // 2) Back-to-back pushes fill the FIFO; 3) held cmd_valid while full
        expect_cmd(4'h1, 8'h21);
        push(4'h1, 8'h21);
        expect_cmd(4'h2, 8'h43);
        push(4'h2, 8'h43);
        expect_cmd(4'h3, 8'h65);
        push(4'h3, 8'h65);
        expect_cmd(4'h4, 8'h87);
        push(4'h4, 8'h87);
        expect_cmd(4'h6, 8'hA9);
        push(4'h6, 8'hA9);
        check("t2_level_full", fifo_level, 3'd4);
        check("t2_ready_full", cmd_ready, 1'b0);
        expect_cmd(4'hE, 8'hCB);
        push(4'hE, 8'hCB);                       // waits for ready
        check("t3_level_after", fifo_level, 3'd4);
        wait_idle(400);
        bad = 0;
        for (int i = 1; i < rise_t.size(); i++) begin
            if (rise_t[i] - rise_t[i-1] != 4) bad++;
        end
        check("t2_strobe_spacing", bad, 0);
        compare_q("t2");

        // 4) Reset during strobe of the 2nd nibble
        push(4'h7, 8'h5C);
        push(4'h9, 8'h12);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(WR && !A0) && n < 100);
        check("t4_reach_strobe", WR && !A0, 1'b1);
        #1 RST = 1'b1;
        @(negedge clk);
        check("t4_WR", WR, 1'b0);
        check("t4_D", D, 4'h0);
        check("t4_A0", A0, 1'b0);
        check("t4_level", fifo_level, 3'd0);
        check("t4_busy", busy, 1'b0);
        @(posedge clk);
        #1 RST = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        exp_q.push_back({1'b1, 4'h7});
        exp_q.push_back({1'b0, 4'hC});
        compare_q("t4_partial");
        expect_cmd(4'h3, 8'h4E);
        push(4'h3, 8'h4E);
        wait_idle(100);
        compare_q("t4_after");

        // 5) Alternate timing instance: {F, 00}
        check("t5_ready", cmd_ready2, 1'b1);
        cmd_valid2 = 1'b1;
        cmd_addr2  = 4'hF;
        cmd_data2  = 8'h00;
        @(posedge clk);
        #1 cmd_valid2 = 1'b0;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (busy2 && n < 100);
        check("t5_idle", busy2, 1'b0);
        check("t5_count", got2_q.size(), 3);
        if (got2_q.size() == 3 && t2_q.size() == 3 && w2_q.size() == 3) begin
            check("t5_w0", got2_q[0], {1'b1, 4'hF});
            check("t5_w1", got2_q[1], {1'b0, 4'h0});
            check("t5_w2", got2_q[2], {1'b0, 4'h0});
            check("t5_gap01", t2_q[1] - t2_q[0], 6);
            check("t5_gap12", t2_q[2] - t2_q[1], 6);
            for (int i = 0; i < 3; i++) check("t5_width", w2_q[i], 1);
        end

        // 6) Random stream of 200 commands
        for (int i = 0; i < 200; i++) begin
            ra = 4'($urandom_range(0, 15));
            rd = 8'($urandom_range(0, 255));
            expect_cmd(ra, rd);
            push(ra, rd);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 5)) @(posedge clk);
                #1;
            end
        end
        wait_idle(4000);
        compare_q("t6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
